// File: rtl/wb_pwmaudio_fifo.sv
// Multi-channel Wishbone PWM audio output fed from a frame FIFO, with a rate timer and low-water interrupt.
// Build option SIGMA_DELTA_EN swaps the bit-reversed PWM compare for first-order sigma-delta modulators.
module wb_pwmaudio_fifo #(
    parameter int NCH            = 2,
    parameter int SAMPLE_BITS    = 16,
    parameter int LGFIFO         = 5,
    parameter int TIMING_BITS    = 16,
    parameter int DEFAULT_RELOAD = 2268
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wb_cyc,
    input  logic             i_wb_stb,
    input  logic             i_wb_we,
    input  logic [1:0]       i_wb_addr,
    input  logic [31:0]      i_wb_data,
    output logic             o_wb_ack,
    output logic             o_wb_stall,
    output logic [31:0]      o_wb_data,
    output logic [NCH-1:0]   o_pwm,
    output logic             o_int
);
    localparam int DEPTH = 1 << LGFIFO;
    localparam int SB    = SAMPLE_BITS;
    localparam int FW    = NCH * SB;
    localparam int LW    = LGFIFO + 1;

    logic unused_ok;
    assign unused_ok = i_wb_cyc;

    logic wb_wr, push_req, reload_wr, ctrl_wr, flush;
    logic tick, fifo_empty, fifo_full, do_pop, do_push, unf_set, ovf_set;

    logic [LGFIFO-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_addr;
    logic [LW-1:0]          level_q, level_d;
    logic [FW-1:0]          playing_q, playing_d, push_frame, mem_rd_q;
    logic [FW-1:0]          mem_q [0:DEPTH-1];
    logic [TIMING_BITS-1:0] reload_q, reload_d, timer_q, timer_d, reload_wdata;
    logic                   en_q, en_d, unf_q, unf_d, ovf_q, ovf_d;
    logic [LW-1:0]          thresh_q, thresh_d;
    logic                   ack_q, int_q, int_d;
    logic [31:0]            wb_data_q, rd_data;
    logic [SB-1:0]          u [NCH];

    assign wb_wr     = i_wb_stb & i_wb_we;
    assign push_req  = wb_wr & (i_wb_addr == 2'd0);
    assign reload_wr = wb_wr & (i_wb_addr == 2'd1);
    assign ctrl_wr   = wb_wr & (i_wb_addr == 2'd2);
    assign flush     = ctrl_wr & i_wb_data[1];

    assign tick       = en_q & (timer_q == '0);
    assign fifo_empty = (level_q == '0);
    assign fifo_full  = (level_q == LW'(DEPTH));
    assign do_pop     = tick & ~fifo_empty;
    // A full FIFO still takes a push when the same cycle pops a frame.
    assign do_push    = push_req & ~flush & ~i_rst & (~fifo_full | do_pop);
    assign ovf_set    = push_req & ~flush & fifo_full & ~do_pop;
    assign unf_set    = tick & fifo_empty;

    assign reload_wdata = (i_wb_data[TIMING_BITS-1:0] < TIMING_BITS'(2)) ?
                          TIMING_BITS'(2) : i_wb_data[TIMING_BITS-1:0];

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            assign push_frame[gi*SB +: SB] = i_wb_data[16*gi+16-SB +: SB];
            assign u[gi] = {~playing_q[gi*SB+SB-1], playing_q[gi*SB +: SB-1]};
        end
    endgenerate

    always_comb begin
        wr_ptr_d  = wr_ptr_q + LGFIFO'(do_push);
        rd_ptr_d  = flush ? wr_ptr_q : rd_ptr_q + LGFIFO'(do_pop);
        level_d   = flush ? '0 : level_q + LW'(do_push) - LW'(do_pop);
        playing_d = do_pop ? mem_rd_q : playing_q;
        reload_d  = reload_wr ? reload_wdata : reload_q;
        timer_d   = (!en_q || tick) ? reload_q - TIMING_BITS'(1) : timer_q - TIMING_BITS'(1);
        en_d      = ctrl_wr ? i_wb_data[0] : en_q;
        thresh_d  = ctrl_wr ? i_wb_data[8+LGFIFO:8] : thresh_q;
        unf_d     = (unf_q & ~(ctrl_wr & i_wb_data[30])) | unf_set;
        ovf_d     = (ovf_q & ~(ctrl_wr & i_wb_data[31])) | ovf_set;
        int_d     = en_q & ((level_q <= thresh_q) | unf_q | ovf_q);
    end

    always_comb begin
        rd_data = '0;
        case (i_wb_addr)
            2'd0: begin
                for (int k = 0; k < NCH; k++)
                    rd_data[16*k+16-SB +: SB] = playing_q[k*SB +: SB];
            end
            2'd1: rd_data[TIMING_BITS-1:0] = reload_q;
            2'd2: begin
                rd_data[0]             = en_q;
                rd_data[8+LGFIFO:8]    = thresh_q;
            end
            default: begin
                rd_data[LGFIFO:0] = level_q;
                rd_data[16]       = fifo_empty;
                rd_data[17]       = fifo_full;
                rd_data[30]       = unf_q;
                rd_data[31]       = ovf_q;
            end
        endcase
    end

    // The read port is addressed by the next read pointer so mem_rd_q always holds the
    // head frame; a write landing on that slot is forwarded so a fresh push is never stale.
    assign rd_addr = i_rst ? '0 : rd_ptr_d;

    always_ff @(posedge i_clk) begin
        if (do_push)
            mem_q[wr_ptr_q] <= push_frame;
        if (do_push && (wr_ptr_q == rd_addr))
            mem_rd_q <= push_frame;
        else
            mem_rd_q <= mem_q[rd_addr];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            playing_q <= '0;
            reload_q  <= TIMING_BITS'(DEFAULT_RELOAD);
            timer_q   <= TIMING_BITS'(DEFAULT_RELOAD - 1);
            en_q      <= 1'b0;
            thresh_q  <= LW'(DEPTH / 2);
            unf_q     <= 1'b0;
            ovf_q     <= 1'b0;
            ack_q     <= 1'b0;
            wb_data_q <= '0;
            int_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            playing_q <= playing_d;
            reload_q  <= reload_d;
            timer_q   <= timer_d;
            en_q      <= en_d;
            thresh_q  <= thresh_d;
            unf_q     <= unf_d;
            ovf_q     <= ovf_d;
            ack_q     <= i_wb_stb;
            if (i_wb_stb)
                wb_data_q <= rd_data;
            int_q     <= int_d;
        end
    end

`ifdef SIGMA_DELTA_EN
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_sd
            logic [SB:0] acc_q;
            always_ff @(posedge i_clk) begin
                if (i_rst || !en_q)
                    acc_q <= '0;
                else
                    acc_q <= {1'b0, acc_q[SB-1:0]} + {1'b0, u[gi]};
            end
            assign o_pwm[gi] = acc_q[SB];
        end
    endgenerate
`else
    logic [SB-1:0]  cnt_q, brcnt;
    logic [NCH-1:0] pwm_q, pwm_d;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
            pwm_q <= '0;
        end else begin
            cnt_q <= cnt_q + SB'(1);
            pwm_q <= pwm_d;
        end
    end

    // Bit-reversing the counter spreads each sample's high time across the whole period.
    generate
        for (gi = 0; gi < SB; gi++) begin : g_brev
            assign brcnt[gi] = cnt_q[SB-1-gi];
        end
        for (gi = 0; gi < NCH; gi++) begin : g_cmp
            assign pwm_d[gi] = en_q & (u[gi] > brcnt);
        end
    endgenerate

    assign o_pwm = pwm_q;
`endif

    assign o_wb_ack   = ack_q;
    assign o_wb_stall = 1'b0;
    assign o_wb_data  = wb_data_q;
    assign o_int      = int_q;
endmodule

// File: tb/tb_wb_pwmaudio_fifo.sv
// Scoreboard bench for wb_pwmaudio_fifo: a queue-based reference model predicts every bus response.
module tb_wb_pwmaudio_fifo;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [1:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic        ack, stall, int_o;
    logic [31:0] rdata;
    logic [1:0]  pwm;

    wb_pwmaudio_fifo dut (
        .i_clk(clk), .i_rst(rst), .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
        .i_wb_addr(addr), .i_wb_data(wdata), .o_wb_ack(ack), .o_wb_stall(stall),
        .o_wb_data(rdata), .o_pwm(pwm), .o_int(int_o)
    );

    typedef struct {
        bit          is_rd;
        logic [1:0]  addr;
        logic [31:0] data;
        bit          intv;
        logic [1:0]  pwm;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;

    // Reference model: FIFO as a queue, timer as a phase within the current period.
    logic [31:0] mq[$];
    logic [31:0] m_play;
    int          m_reload, m_period, m_phase, m_thr, m_cnt;
    bit          m_en, m_unf, m_ovf;

    function automatic logic [15:0] bitrev16(input logic [15:0] x);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[i] = x[15-i];
        return r;
    endfunction

    function automatic logic [31:0] m_read(input logic [1:0] a);
        int lvl;
        lvl = mq.size();
        case (a)
            2'd0: return m_play;
            2'd1: return 32'(m_reload);
            2'd2: return 32'(m_thr << 8) | 32'(m_en);
            default: return 32'(lvl) | ((lvl == 0) ? 32'h10000 : 32'h0) |
                            ((lvl == 32) ? 32'h20000 : 32'h0) |
                            (m_unf ? 32'h40000000 : 32'h0) | (m_ovf ? 32'h80000000 : 32'h0);
        endcase
    endfunction

    function automatic bit m_int();
        return m_en && ((mq.size() <= m_thr) || m_unf || m_ovf);
    endfunction

    function automatic logic [1:0] m_pwm();
        logic [1:0]  r;
        logic [15:0] uk;
        for (int k = 0; k < 2; k++) begin
            uk = m_play[16*k +: 16] ^ 16'h8000;
            r[k] = m_en && (uk > bitrev16(16'(m_cnt)));
        end
        return r;
    endfunction

    function automatic void model_step();
        bit tick, push, rel, ctl, unf_set, ovf_set, old_en;
        int old_reload;
        if (rst) begin
            mq.delete();
            m_play = '0; m_reload = 2268; m_period = 2268; m_phase = 0;
            m_thr = 16; m_cnt = 0; m_en = 0; m_unf = 0; m_ovf = 0;
            return;
        end
        tick = m_en && (m_phase == m_period - 1);
        push = stb && we && (addr == 2'd0);
        rel  = stb && we && (addr == 2'd1);
        ctl  = stb && we && (addr == 2'd2);
        old_reload = m_reload; old_en = m_en;
        unf_set = 0; ovf_set = 0;
        if (tick) begin
            if (mq.size() > 0) m_play = mq.pop_front();
            else unf_set = 1;
        end
        if (push) begin
            if (mq.size() < 32) mq.push_back(wdata);
            else ovf_set = 1;
        end
        if (rel) m_reload = (wdata[15:0] < 16'd2) ? 2 : int'(wdata[15:0]);
        if (ctl) begin
            m_en = wdata[0];
            m_thr = int'(wdata[13:8]);
            if (wdata[1]) mq.delete();
            if (wdata[30]) m_unf = 0;
            if (wdata[31]) m_ovf = 0;
        end
        m_unf = m_unf | unf_set;
        m_ovf = m_ovf | ovf_set;
        if (!old_en || tick) begin
            m_phase = 0;
            m_period = old_reload;
        end else begin
            m_phase++;
        end
        m_cnt = (m_cnt + 1) % 65536;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s got=%08h want=%08h", nm, act, want);
        end
    endtask

    task automatic step_clk();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step_clk();
    endtask

    task automatic bus(input bit w, input logic [1:0] a, input logic [31:0] d,
                       input bit use_lit, input logic [31:0] lit, input string nm);
        exp_t e;
        stb = 1'b1; we = w; addr = a; wdata = d;
        e.is_rd = !w;
        e.addr  = a;
        e.data  = use_lit ? lit : m_read(a);
        e.intv  = m_int();
        e.pwm   = m_pwm();
        e.name  = nm;
        sb.push_back(e);
        step_clk();
        stb = 1'b0; we = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d, input string nm);
        bus(1'b1, a, d, 1'b0, 32'h0, nm);
    endtask
    task automatic rd(input logic [1:0] a, input string nm);
        bus(1'b0, a, 32'h0, 1'b0, 32'h0, nm);
    endtask
    task automatic rdx(input logic [1:0] a, input logic [31:0] lit, input string nm);
        bus(1'b0, a, 32'h0, 1'b1, lit, nm);
    endtask

    // Monitor: every acknowledge retires the oldest expected transaction.
    always @(negedge clk) begin
        if (ack) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL spurious_ack got=1 want=0");
            end else begin
                mon_e = sb.pop_front();
                if (mon_e.is_rd) begin
                    checks++;
                    if (rdata !== mon_e.data) begin
                        failures++;
                        $display("FAIL %s data got=%08h want=%08h", mon_e.name, rdata, mon_e.data);
                    end
                end
                checks++;
                if (int_o !== mon_e.intv) begin
                    failures++;
                    $display("FAIL %s o_int got=%0b want=%0b", mon_e.name, int_o, mon_e.intv);
                end
                checks++;
                if (pwm !== mon_e.pwm) begin
                    failures++;
                    $display("FAIL %s o_pwm got=%b want=%b", mon_e.name, pwm, mon_e.pwm);
                end
                $display("txn %-16s %s a=%0d d=%08h int=%0b pwm=%b", mon_e.name,
                         mon_e.is_rd ? "rd" : "wr", mon_e.addr, rdata, int_o, pwm);
            end
        end
    end

    logic [31:0] f33 [33];
    logic [31:0] g32 [32];
    logic [31:0] d;
    int c0, c1, r;

    initial begin
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        rdx(2'd3, 32'h00010000, "rst_status");
        rdx(2'd1, 32'd2268, "rst_reload");
        rdx(2'd0, 32'h0, "rst_data");
        rdx(2'd2, 32'h00001000, "rst_ctrl");

        // Paced playback with reload 4 and threshold 2
        wr(2'd1, 32'd4, "reload4");
        wr(2'd2, 32'h00000200, "thr2");
        wr(2'd0, 32'h7FFF8000, "push_a");
        wr(2'd0, 32'h00000000, "push_b");
        wr(2'd0, 32'h40004000, "push_c");
        rdx(2'd3, 32'h00000003, "level3");
        wr(2'd2, 32'h00000201, "enable");
        for (int i = 0; i < 14; i++) rd(2'd3, "drain_status");
        rdx(2'd0, 32'h40004000, "play_c");

        // Duty over one full counter period
        wr(2'd0, 32'h7FFF8000, "push_duty");
        idle(6);
        rdx(2'd0, 32'h7FFF8000, "play_duty");
        c0 = 0; c1 = 0;
        for (int i = 0; i < 65536; i++) begin
            step_clk();
            c0 += int'(pwm[0]);
            c1 += int'(pwm[1]);
        end
        check("duty_ch0", 32'(c0), 32'd0);
        check("duty_ch1", 32'(c1), 32'd65535);

        // Overflow with 33 pushes while disabled
        wr(2'd2, 32'hC0001000, "dis_clr");
        wr(2'd2, 32'hC0001000, "dis_clr2");
        for (int i = 0; i < 33; i++) begin
            f33[i] = $urandom;
            wr(2'd0, f33[i], "push33");
        end
        rdx(2'd3, 32'h80020020, "full_ovf");
        wr(2'd1, 32'd2, "reload2");
        wr(2'd2, 32'h80001001, "en_clr_ovf");
        for (int i = 0; i < 70; i++) rd(2'd0, "drain_data");
        rdx(2'd0, f33[31], "last_kept");

        // Underflow on an empty FIFO
        wr(2'd2, 32'hC0000000, "dis_clr");
        wr(2'd2, 32'hC0000000, "dis_clr2");
        rdx(2'd3, 32'h00010000, "empty_clr");
        wr(2'd2, 32'h00000001, "en_empty");
        idle(3);
        rdx(2'd3, 32'h40010000, "unf_set");
        rdx(2'd0, f33[31], "unf_hold");
        wr(2'd2, 32'h40000001, "unf_clr");
        rd(2'd3, "after_unf_clr");
        wr(2'd2, 32'hC0001000, "dis_clr");
        wr(2'd2, 32'hC0001000, "dis_clr2");

        // Push on the tick cycle while full
        for (int i = 0; i < 32; i++) begin
            g32[i] = $urandom;
            wr(2'd0, g32[i], "push32");
        end
        rdx(2'd3, 32'h00020020, "full32");
        wr(2'd2, 32'h00001001, "en_tick");
        idle(1);
        wr(2'd0, 32'h12345678, "push_on_tick");
        wr(2'd2, 32'h00001000, "dis");
        rdx(2'd3, 32'h00020020, "push_tick_lvl");
        rdx(2'd0, g32[0], "pop_front");

        // Flush keeps the playing frame
        wr(2'd0, 32'hDEADBEEF, "push_full");
        wr(2'd2, 32'h80001002, "flush");
        rdx(2'd3, 32'h00010000, "flush_empty");
        rdx(2'd0, g32[0], "flush_keep_play");
        wr(2'd0, 32'h01020304, "push_post");
        rdx(2'd3, 32'h00000001, "post_flush_lvl");

        // Randomized traffic
        for (int i = 0; i < 700; i++) begin
            r = $urandom_range(0, 9);
            if (r <= 3) begin
                wr(2'd0, $urandom, "rnd_push");
            end else if (r <= 5) begin
                rd(2'($urandom_range(0, 3)), "rnd_rd");
            end else if (r == 6) begin
                d = ($urandom & 32'hFFFF0000) | 32'($urandom_range(0, 6));
                wr(2'd1, d, "rnd_reload");
            end else if (r == 7) begin
                d = $urandom;
                d[0] = ($urandom_range(0, 3) != 0);
                d[1] = ($urandom_range(0, 7) == 0);
                wr(2'd2, d, "rnd_ctrl");
            end else begin
                idle($urandom_range(0, 3));
            end
        end

        // Reset during playback
        wr(2'd1, 32'd3, "reload3");
        wr(2'd0, 32'h11112222, "push_r1");
        wr(2'd0, 32'h33334444, "push_r2");
        wr(2'd2, 32'h00001001, "en_r");
        idle(5);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        rdx(2'd3, 32'h00010000, "mid_rst_status");
        rdx(2'd1, 32'd2268, "mid_rst_reload");
        rdx(2'd0, 32'h0, "mid_rst_data");
        rdx(2'd2, 32'h00001000, "mid_rst_ctrl");

        idle(3);
        check("ack_outstanding", 32'(sb.size()), 32'd0);
        check("stall", 32'(stall), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/wb_pwmaudio_fifo.md
Name: wb_pwmaudio_fifo

Overview:
Multi-channel Wishbone PWM audio output with a sample FIFO, so the CPU can refill in bursts instead of once per sample. A programmable sample-rate timer pops one frame (one sample per channel) per tick. Each frame drives NCH bit-reversed PWM outputs. A level-based low-water interrupt tells the CPU to refill. The block drops into the same Wishbone peripheral slot as the single-sample audio controller.

Parameters:
NCH, 2, channel count (1 or 2); channel k sample in i_wb_data[16k+15:16k]
SAMPLE_BITS, 16, sample resolution (8..16); the top SAMPLE_BITS of each 16-bit half are used
LGFIFO, 5, log2 FIFO depth (depth 32 frames)
TIMING_BITS, 16, rate timer width
DEFAULT_RELOAD, 2268, reset sample period in clocks (44.1 kHz at 100 MHz)

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_wb_cyc  in  1  bus cycle (unused)
i_wb_stb  in  1  strobe
i_wb_we  in  1  write enable
i_wb_addr  in  2  register select
i_wb_data  in  32  write data
o_wb_ack  out  1  acknowledge
o_wb_stall  out  1  stall, tied 0
o_wb_data  out  32  read data
o_pwm  out  NCH  PWM outputs, one per channel
o_int  out  1  low-water interrupt, level-sensitive

Behaviour:
Decided: reset i_rst, synchronous, active-high; clock i_clk.
Reset values:
- FIFO empty; reload=DEFAULT_RELOAD; timer=DEFAULT_RELOAD-1.
- en=0; threshold=depth/2; sticky bits clear.
- Playing samples 0 (signed); o_pwm=0; o_int=0; o_wb_ack=0.
Wishbone:
- o_wb_ack=1 exactly one cycle after every i_wb_stb; no stall.
- o_wb_data is registered and valid in the ack cycle.
Registers:
- addr0 DATA, write: push frame (NCH signed two's-complement samples). If FIFO is full, discard the frame and set OVF sticky.
- addr0 DATA, read: currently playing samples, signed, packed as on write.
- addr1 RELOAD, write: reload=data[TIMING_BITS-1:0]; values <2 clamp to 2. Takes effect at the next tick.
- addr1 RELOAD, read: current reload value.
- addr2 CTRL, write: bit0 en; bit1 flush (self-clearing, empties FIFO); bits[8+LGFIFO:8] threshold; bit30 write-1-clears UNF; bit31 write-1-clears OVF.
- addr2 CTRL, read: en and threshold.
- addr3 STATUS, read-only: [LGFIFO:0] fill level; bit16 empty; bit17 full; bit30 UNF; bit31 OVF.
Rate timer:
- While en=1: counts down from reload-1 to 0. At 0, assert tick for one cycle and reload.
- While en=0: held at reload-1, no ticks.
Tick:
- FIFO non-empty: pop one frame into the playing registers.
- FIFO empty: hold the last frame and set UNF.
PWM:
- Free-running SAMPLE_BITS counter, bit-reversed.
- u_k = playing_k with MSB inverted (offset binary).
- o_pwm[k] registered = en & (u_k > brcnt). Signed 0 gives 50% duty; most-negative gives constant 0.
- en=0 forces o_pwm=0 on the next cycle.
o_int:
- Registered, o_int = en & ((level <= threshold) | UNF | OVF).
Boundaries:
- Push and pop in the same cycle: both happen; level unchanged. Push is accepted even when full.
- Push on a tick with FIFO empty: the pop sees empty (UNF set) and the pushed frame is stored.
- Flush and push in the same cycle: flush wins and the frame is discarded.
- Flush does not clear the playing registers.
- Reset mid-playback returns every register to its reset value in one cycle.
- Level counter is LGFIFO+1 bits; pointers wrap modulo depth.

Optional Feature:
SIGMA_DELTA_EN: when defined, replaces the bit-reversed PWM compare with a first-order sigma-delta modulator per channel.
- Accumulator is SAMPLE_BITS+1 bits: acc <= acc[SAMPLE_BITS-1:0] + u_k; o_pwm[k] = carry out.
- Accumulator clears on reset and while en=0.
When undefined: bit-reversed PWM as above. Register map is identical in both builds.

Test Plan:
- Reset, read STATUS -> 0x00010000 (empty, level 0); RELOAD reads 2268; o_pwm=0, o_int=0.
- RELOAD=4, threshold=2, push frames 0x7FFF8000, 0x00000000, 0x40004000, en=1 -> pops every 4 clocks; o_int rises when level<=2.
- Over 65536 cycles: ch0 duty 0% (0x8000), ch1 duty 65535/65536 (0x7FFF).
- Push 33 frames with en=0 -> level=32, full=1, OVF=1; 33rd frame absent after draining.
- en=1 with empty FIFO, RELOAD=2 -> UNF=1 after the first tick, playing frame held, o_int=1; CTRL write 0x40000001 clears UNF.
- Push and tick in the same cycle with level 32 -> push accepted, level stays 32, OVF stays 0.
- Flush together with push -> level 0, empty=1, playing frame unchanged.
